elevator_car_driver: RTL
========================

Name: elevator_car_driver

Overview:
- Car-side responder to the elevator FSM. It consumes the FSM's one-hot floor command (floor_one/floor_two/floor_three) and its door request (elevator_open).
- It sequences the hoist motor and door actuator with fixed timing, tracks car position, and reports position, arrival and door status.
- It sits between the FSM outputs and the physical motor/door drivers, or their bench models.

Parameters:
- TRAVEL_CYCLES, 16: cycles of motor drive to move exactly one floor (≥1).
- DOOR_MOVE_CYCLES, 8: cycles for the door to fully open, or fully close (≥1).
- DOOR_HOLD_CYCLES, 32: cycles the door stays fully open before closing (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- floor_one  in  1  target floor 1 (one-hot with the other two floor inputs).
- floor_two  in  1  target floor 2.
- floor_three  in  1  target floor 3.
- elevator_open  in  1  door-open request; may be a single-cycle pulse.
- motor_up  out  1  hoist driving car up.
- motor_down  out  1  hoist driving car down.
- door_opening  out  1  door actuator opening.
- door_closing  out  1  door actuator closing.
- door_open  out  1  door fully open (hold phase).
- door_closed  out  1  door fully closed.
- car_floor  out  2  current car floor; legal values 1..3.
- arrived  out  1  one-cycle pulse when car_floor becomes equal to the target.
- cmd_error  out  1  high while more than one floor input is asserted.

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE, car_floor=2'd1, door_closed=1.
  - motor_up, motor_down, door_opening, door_closing, door_open, arrived, cmd_error = 0.
  - Counter and open_pending cleared.
- Outputs are Moore-decoded from registered state, except cmd_error, which is combinational from the inputs.
- Target decode:
  - Exactly one floor input high → target = 1/2/3.
  - None high → no target.
  - More than one high → cmd_error=1 and the command is treated as no target.
- open_pending:
  - Set on any cycle elevator_open=1, in any state.
  - Cleared on the cycle DOOR_OPENING is entered.
- States and transitions:
  - IDLE:
    - Valid target > car_floor → MOVE_UP, load counter=TRAVEL_CYCLES.
    - Valid target < car_floor → MOVE_DOWN, load counter=TRAVEL_CYCLES.
    - Otherwise, if (elevator_open | open_pending) and (target==car_floor or no target) → DOOR_OPENING.
    - Motion takes priority over door only when target≠car_floor.
  - MOVE_UP / MOVE_DOWN:
    - motor_up / motor_down = 1 throughout; counter decrements each cycle.
    - On the counter==1 cycle, car_floor ±1 at the next edge. Then re-evaluate the target against the new floor:
      - Same direction still needed → stay in the state, reload counter; motor stays high with no gap.
      - Otherwise → IDLE.
    - arrived pulses in the cycle after car_floor updates, if car_floor==target.
    - A target change mid-span takes effect only at the floor boundary; direction reversal passes through IDLE.
    - car_floor saturates: never below 1 or above 3, even under illegal stimulus.
  - DOOR_OPENING:
    - door_opening=1 for DOOR_MOVE_CYCLES cycles, then → DOOR_HOLD.
  - DOOR_HOLD:
    - door_open=1 for DOOR_HOLD_CYCLES cycles.
    - elevator_open=1 during hold reloads the hold counter.
    - Expiry → DOOR_CLOSING.
  - DOOR_CLOSING:
    - door_closing=1 for DOOR_MOVE_CYCLES cycles, then → IDLE with door_closed=1.
    - elevator_open=1 during closing → DOOR_OPENING with counter = cycles already spent closing (reversal from the current position); open_pending is not left set.
- Interlocks (invariants):
  - Motor outputs are high only when the door is fully closed.
  - door_closed=1 only in IDLE or MOVE_*.
  - motor_up and motor_down are never both high.
  - Door actuator outputs are never high while moving.
- Counter width: $clog2(max(TRAVEL_CYCLES, DOOR_MOVE_CYCLES, DOOR_HOLD_CYCLES)+1).
- Reset mid-operation returns to the reset values immediately; no move or door cycle resumes.

Test Plan (TRAVEL_CYCLES=4, DOOR_MOVE_CYCLES=3, DOOR_HOLD_CYCLES=5):
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle.
  - Response: car_floor=1 and door_closed=1 immediately; all other outputs 0.
- Two-floor trip:
  - Stimulus: floor_three held from floor 1.
  - Response: motor_up high for 8 contiguous cycles; car_floor=2 after 4 cycles and 3 after 8; arrived pulses once; motor_up drops.
- Door cycle:
  - Stimulus: single-cycle elevator_open at floor 1 in IDLE, floor_one high.
  - Response: door_opening 3 cycles, door_open 5 cycles, door_closing 3 cycles, then door_closed=1; motors 0 throughout.
- Reopen:
  - Stimulus: elevator_open pulsed in the 2nd closing cycle.
  - Response: door_opening for 2 cycles, then a full 5-cycle hold, then a full 3-cycle close.
- Request latched while moving:
  - Stimulus: elevator_open pulsed while moving from floor 1 to floor 2 with floor_two high.
  - Response: door_opening begins the cycle after IDLE is re-entered at floor 2.
- Error and reset mid-travel:
  - Stimulus: floor_one and floor_three high together.
  - Response: cmd_error=1 and no motion.
  - Stimulus: rst_n low on cycle 2 of a move.
  - Response: car_floor=1 and motor_up=0.

Source files
------------

// File: rtl/elevator_car_driver.sv
// elevator_car_driver: car-side responder to the elevator FSM.
// Sequences the hoist motor and the door actuator with fixed cycle timing,
// tracks the car floor (1..3) and reports arrival, door status and command
// errors.
//
// Handshake: there is no valid/ready pair. The floor inputs are a level-held
// one-hot target sampled every cycle. elevator_open is a level/pulse request
// that is latched into r_open_pending until the door starts opening. All
// outputs except cmd_error are decoded from registered state.
module elevator_car_driver #(
  parameter int TRAVEL_CYCLES    = 16,
  parameter int DOOR_MOVE_CYCLES = 8,
  parameter int DOOR_HOLD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       floor_one,
  input  logic       floor_two,
  input  logic       floor_three,
  input  logic       elevator_open,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_opening,
  output logic       door_closing,
  output logic       door_open,
  output logic       door_closed,
  output logic [1:0] car_floor,
  output logic       arrived,
  output logic       cmd_error,
  output logic [2:0] dbg_state
);

  localparam int MAX_TM  = (TRAVEL_CYCLES > DOOR_MOVE_CYCLES) ? TRAVEL_CYCLES : DOOR_MOVE_CYCLES;
  localparam int MAX_CYC = (MAX_TM > DOOR_HOLD_CYCLES) ? MAX_TM : DOOR_HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] C_TRAVEL = CW'(TRAVEL_CYCLES);
  localparam logic [CW-1:0] C_MOVE   = CW'(DOOR_MOVE_CYCLES);
  localparam logic [CW-1:0] C_HOLD   = CW'(DOOR_HOLD_CYCLES);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_MOVE_UP      = 3'd1,
    S_MOVE_DOWN    = 3'd2,
    S_DOOR_OPENING = 3'd3,
    S_DOOR_HOLD    = 3'd4,
    S_DOOR_CLOSING = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_car_floor;
  logic [1:0]    w_floor_nxt;
  logic          r_arrived;
  logic          w_arrived_nxt;
  logic          r_open_pending;
  logic          w_open_pending_nxt;

  logic [1:0]    w_target;      // 0 means no valid target
  logic          w_has_target;
  logic          w_multi;
  logic [1:0]    w_floor_up;
  logic [1:0]    w_floor_dn;

  // Target decode: exactly one floor line gives a target, anything else none.
  always_comb begin
    w_target = 2'd0;
    w_multi  = (floor_one & floor_two) | (floor_one & floor_three) | (floor_two & floor_three);
    case ({floor_three, floor_two, floor_one})
      3'b001:  w_target = 2'd1;
      3'b010:  w_target = 2'd2;
      3'b100:  w_target = 2'd3;
      default: w_target = 2'd0;
    endcase
    w_has_target = (w_target != 2'd0);
  end

  // Saturating neighbour floors so car_floor never leaves 1..3.
  assign w_floor_up = (r_car_floor >= 2'd3) ? 2'd3 : r_car_floor + 2'd1;
  assign w_floor_dn = (r_car_floor <= 2'd1) ? 2'd1 : r_car_floor - 2'd1;

  // Next-state, counter, floor and arrival logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_floor_nxt   = r_car_floor;
    w_arrived_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_has_target && (w_target > r_car_floor)) begin
          w_state_nxt = S_MOVE_UP;
          w_cnt_nxt   = C_TRAVEL;
        end else if (w_has_target && (w_target < r_car_floor)) begin
          w_state_nxt = S_MOVE_DOWN;
          w_cnt_nxt   = C_TRAVEL;
        end else if (elevator_open || r_open_pending) begin
          // Only reached with target == car_floor or no target.
          w_state_nxt = S_DOOR_OPENING;
          w_cnt_nxt   = C_MOVE;
        end
      end
      S_MOVE_UP: begin
        if (r_cnt <= C_ONE) begin
          // Floor boundary: step the floor and re-evaluate against the new one.
          w_floor_nxt   = w_floor_up;
          w_arrived_nxt = w_has_target && (w_target == w_floor_up);
          if (w_has_target && (w_target > w_floor_up)) begin
            w_cnt_nxt = C_TRAVEL;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_MOVE_DOWN: begin
        if (r_cnt <= C_ONE) begin
          w_floor_nxt   = w_floor_dn;
          w_arrived_nxt = w_has_target && (w_target == w_floor_dn);
          if (w_has_target && (w_target < w_floor_dn)) begin
            w_cnt_nxt = C_TRAVEL;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_DOOR_OPENING: begin
        if (r_cnt <= C_ONE) begin
          w_state_nxt = S_DOOR_HOLD;
          w_cnt_nxt   = C_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_DOOR_HOLD: begin
        if (elevator_open) begin
          w_cnt_nxt = C_HOLD;
        end else if (r_cnt <= C_ONE) begin
          w_state_nxt = S_DOOR_CLOSING;
          w_cnt_nxt   = C_MOVE;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_DOOR_CLOSING: begin
        if (elevator_open) begin
          // Reverse from the current position: reopen for as long as we closed,
          // counting the current closing cycle.
          w_state_nxt = S_DOOR_OPENING;
          w_cnt_nxt   = C_MOVE - r_cnt + C_ONE;
        end else if (r_cnt <= C_ONE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Door request latch: entering DOOR_OPENING consumes it, any request sets it.
  always_comb begin
    w_open_pending_nxt = r_open_pending;
    if ((w_state_nxt == S_DOOR_OPENING) && (r_state != S_DOOR_OPENING)) begin
      w_open_pending_nxt = 1'b0;
    end else if (elevator_open) begin
      w_open_pending_nxt = 1'b1;
    end
  end

  // State, counter, floor, arrival and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_car_floor    <= 2'd1;
      r_arrived      <= 1'b0;
      r_open_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_car_floor    <= w_floor_nxt;
      r_arrived      <= w_arrived_nxt;
      r_open_pending <= w_open_pending_nxt;
    end
  end

  // Moore output decode; motors only run in states where the door is closed.
  assign motor_up     = (r_state == S_MOVE_UP);
  assign motor_down   = (r_state == S_MOVE_DOWN);
  assign door_opening = (r_state == S_DOOR_OPENING);
  assign door_open    = (r_state == S_DOOR_HOLD);
  assign door_closing = (r_state == S_DOOR_CLOSING);
  assign door_closed  = (r_state == S_IDLE) || (r_state == S_MOVE_UP) || (r_state == S_MOVE_DOWN);
  assign car_floor    = r_car_floor;
  assign arrived      = r_arrived;
  assign cmd_error    = w_multi;
  assign dbg_state    = r_state;

endmodule
